// File: rtl/sbox0_inv_search.sv
// sbox0_inv_search: sequential inverse of the CLEFIA S-box S0.
// A request carries an S0 output byte y_in. The block sweeps candidate inputs
// through LANES copies of the combinational sbox0 until one maps onto y_in,
// then presents that input byte on x_out.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   block can accept a request (registered)
//   y_in       S0 output value to invert
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   x_out      recovered S0 input (registered)
//   not_found  sweep ended without a match; only a corrupted sbox0 can cause it

// sbox0: combinational CLEFIA S0 built from four 4-bit S-boxes and a
// GF(2^4) mixing step (polynomial z^4 + z + 1).
//   x  input byte
//   y  S0(x)
module sbox0 (
    input  logic [7:0] x,
    output logic [7:0] y
);
    localparam logic [3:0] SS0 [16] = '{4'he, 4'h6, 4'hc, 4'ha, 4'h8, 4'h7, 4'h2, 4'hf,
                                       4'hb, 4'h1, 4'h4, 4'h0, 4'h5, 4'h9, 4'hd, 4'h3};
    localparam logic [3:0] SS1 [16] = '{4'h6, 4'h4, 4'h0, 4'hd, 4'h2, 4'hb, 4'ha, 4'h3,
                                       4'h9, 4'hc, 4'he, 4'hf, 4'h8, 4'h7, 4'h5, 4'h1};
    localparam logic [3:0] SS2 [16] = '{4'hb, 4'h8, 4'h5, 4'he, 4'ha, 4'h6, 4'h4, 4'hc,
                                       4'hf, 4'h7, 4'h2, 4'h3, 4'h1, 4'h0, 4'hd, 4'h9};
    localparam logic [3:0] SS3 [16] = '{4'ha, 4'h2, 4'h6, 4'hd, 4'h3, 4'h4, 4'h5, 4'he,
                                       4'h0, 4'h7, 4'h8, 4'h9, 4'hb, 4'hf, 4'hc, 4'h1};

    // multiply by z in GF(2^4): shift, fold z^4 back as z + 1
    function automatic logic [3:0] mul2(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
    endfunction

    logic [3:0] t0, t1, u0, u1;

    always_comb begin
        t0 = SS0[x[7:4]];
        t1 = SS1[x[3:0]];
        u0 = t0 ^ mul2(t1);
        u1 = mul2(t0) ^ t1;
        y  = {SS2[u0], SS3[u1]};
    end
endmodule

module sbox0_inv_search #(
    parameter int LANES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] y_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] x_out,
    output logic       not_found
);
    // state  | meaning
    // IDLE   | waiting for a request, in_ready high once out of reset
    // SEARCH | sweeping base..base+LANES-1 against the latched y each cycle
    // DONE   | result held on x_out/not_found until out_ready

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_lanes_check
        $error("sbox0_inv_search: LANES must be 1, 2, 4 or 8");
    end

    localparam logic [7:0] LAST_BASE = 8'(256 - LANES);
    localparam logic [7:0] STEP      = 8'(LANES);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t     state;
    logic [7:0] base;
    logic [7:0] y_reg;
    logic [7:0] cand     [LANES];
    logic [7:0] sbox_out [LANES];
    logic       hit;
    logic [7:0] hit_x;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // base is a multiple of LANES, so base + i never carries past 8 bits
        assign cand[i] = base + 8'(i);
        sbox0 u_sbox0 (
            .x (cand[i]),
            .y (sbox_out[i])
        );
    end

    // walk from the top lane down so the lowest matching lane wins
    always_comb begin
        hit   = 1'b0;
        hit_x = 8'h00;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (sbox_out[i] == y_reg) begin
                hit   = 1'b1;
                hit_x = cand[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            x_out     <= 8'h00;
            not_found <= 1'b0;
            base      <= 8'h00;
            y_reg     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        y_reg    <= y_in;
                        base     <= 8'h00;
                        in_ready <= 1'b0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        x_out     <= hit_x;
                        not_found <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (base == LAST_BASE) begin
                        x_out     <= 8'h00;
                        not_found <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        base <= base + STEP;
                    end
                end
                DONE: begin
                    // the handshake edge only returns to IDLE; accepting
                    // starts on the following edge at the earliest
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sbox0_inv_search.sv
// tb_sbox0_inv_search: scoreboard bench for sbox0_inv_search.
// Four instances (LANES = 1, 2, 4, 8) share clock and reset. Stimulus pushes
// the expected {x, not_found, latency} per instance; a monitor pops and
// compares whenever out_valid rises on that instance.
module tb_sbox0_inv_search;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [3:0][7:0] y_in;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [3:0][7:0] x_out;
    logic [3:0]      not_found;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] x;
        logic       nf;
        int         lat;
    } exp_t;

    exp_t       exp_q [4][$];
    int         acc_edge [4];
    logic [3:0] prev_ov;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sbox0_inv_search #(.LANES(1 << g)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .y_in      (y_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .x_out     (x_out[g]),
            .not_found (not_found[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference S0, nibble tables packed MSB-first
    function automatic logic [3:0] nib(input logic [63:0] t, input logic [3:0] i);
        return t[(15 - int'(i)) * 4 +: 4];
    endfunction

    function automatic logic [3:0] xtime4(input logic [3:0] a);
        logic [3:0] m;
        m = {a[2:0], 1'b0};
        if (a[3]) m = m ^ 4'b0011;
        return m;
    endfunction

    function automatic logic [7:0] s0_model(input logic [7:0] x);
        logic [63:0] ss0, ss1, ss2, ss3;
        logic [3:0]  t0, t1, u0, u1;
        ss0 = 64'he6ca872fb14059d3;
        ss1 = 64'h640d2ba39cef8751;
        ss2 = 64'hb85ea64cf72310d9;
        ss3 = 64'ha26d345e0789bfc1;
        t0  = nib(ss0, x[7:4]);
        t1  = nib(ss1, x[3:0]);
        u0  = t0 ^ xtime4(t1);
        u1  = xtime4(t0) ^ t1;
        return {nib(ss2, u0), nib(ss3, u1)};
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, k, act, req);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rst) begin
                    prev_ov[k] = 1'b0;
                end else begin
                    if (in_valid[k] && in_ready[k]) acc_edge[k] = cyc + 1;
                    if (out_valid[k] && !prev_ov[k]) begin
                        if (exp_q[k].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_output dut%0d actual x_out=%0h required=no output",
                                     k, x_out[k]);
                        end else begin
                            e = exp_q[k].pop_front();
                            chk("x_out", k, 32'(x_out[k]), 32'(e.x));
                            chk("not_found", k, 32'(not_found[k]), 32'(e.nf));
                            chk("latency", k, 32'(cyc - acc_edge[k]), 32'(e.lat));
                        end
                    end
                    prev_ov[k] = out_valid[k];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [7:0] y, input logic [7:0] ex,
                         input logic nf, input int lat, input bit push);
        exp_t e;
        int   n = 0;
        while (!in_ready[k] && n < 400) begin
            tick();
            n++;
        end
        if (!in_ready[k]) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut%0d actual in_ready=0 required=1", k);
            return;
        end
        if (push) begin
            e.x   = ex;
            e.nf  = nf;
            e.lat = lat;
            exp_q[k].push_back(e);
        end
        in_valid[k] = 1'b1;
        y_in[k]     = y;
        tick();
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input int budget);
        int n = 0;
        while (!out_valid[k] && n < budget) begin
            tick();
            n++;
        end
        chk("out_valid_arrives", k, 32'(out_valid[k]), 32'd1);
    endtask

    task automatic run_directed(input int k, input logic [7:0] y, input logic [7:0] ex,
                                input int lat);
        issue(k, y, ex, 1'b0, lat, 1'b1);
        wait_out(k, lat + 5);
        tick();
        tick();
    endtask

    initial begin
        #(900_000);
        $display("FAIL watchdog actual cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit pending;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '1;
        y_in      = '0;
        prev_ov   = '0;
        for (int k = 0; k < 4; k++) acc_edge[k] = 0;
        fork
            monitor_loop();
        join_none

        // reset state
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            chk("rst_in_ready", k, 32'(in_ready[k]), 32'd0);
            chk("rst_out_valid", k, 32'(out_valid[k]), 32'd0);
            chk("rst_x_out", k, 32'(x_out[k]), 32'd0);
            chk("rst_not_found", k, 32'(not_found[k]), 32'd0);
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) chk("post_rst_in_ready", k, 32'(in_ready[k]), 32'd1);

        // directed vectors
        run_directed(0, 8'h57, 8'h00, 1);
        run_directed(0, 8'h21, 8'had, 174);
        run_directed(0, 8'h00, 8'h45, 70);
        run_directed(2, 8'h9a, 8'hf0, 61);
        run_directed(2, 8'hd9, 8'hd6, 54);

        // backpressure
        out_ready[0] = 1'b0;
        issue(0, 8'h57, 8'h00, 1'b0, 1, 1'b1);
        wait_out(0, 10);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = (i % 2 == 0);
            y_in[0]     = 8'h21;
            tick();
            chk("bp_out_valid", 0, 32'(out_valid[0]), 32'd1);
            chk("bp_x_out", 0, 32'(x_out[0]), 32'h00);
            chk("bp_not_found", 0, 32'(not_found[0]), 32'd0);
            chk("bp_in_ready", 0, 32'(in_ready[0]), 32'd0);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        chk("bp_release_out_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("bp_release_in_ready", 0, 32'(in_ready[0]), 32'd1);
        repeat (5) tick();
        chk("bp_no_extra_result", 0, 32'(out_valid[0]), 32'd0);

        // reset in the middle of a search
        issue(0, 8'h21, 8'had, 1'b0, 174, 1'b0);
        repeat (49) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", 0, 32'(in_ready[0]), 32'd0);
        chk("midrst_out_valid", 0, 32'(out_valid[0]), 32'd0);
        tick();
        chk("midrst_in_ready_after", 0, 32'(in_ready[0]), 32'd1);
        repeat (200) tick();
        chk("midrst_no_result", 0, 32'(out_valid[0]), 32'd0);
        run_directed(0, 8'h9a, 8'hf0, 241);

        // round trip on all four instances in lockstep
        for (int x = 0; x < 256 && failures == 0; x++) begin
            n = 0;
            while (in_ready != 4'hf && n < 20) begin
                tick();
                n++;
            end
            chk("rt_ready", 0, 32'(in_ready), 32'hf);
            for (int k = 0; k < 4; k++) begin
                exp_t e;
                e.x   = 8'(x);
                e.nf  = 1'b0;
                e.lat = x / (1 << k) + 1;
                exp_q[k].push_back(e);
                in_valid[k] = 1'b1;
                y_in[k]     = s0_model(8'(x));
            end
            tick();
            in_valid = '0;
            n = 0;
            pending = 1'b1;
            while (pending && n < 300) begin
                tick();
                n++;
                pending = 1'b0;
                for (int k = 0; k < 4; k++) if (exp_q[k].size() != 0) pending = 1'b1;
            end
            if (pending) begin
                checks++;
                failures++;
                $display("FAIL rt_timeout x=%0h actual=no result required=result", x);
                for (int k = 0; k < 4; k++) exp_q[k].delete();
            end
            tick();
        end

        repeat (3) tick();
        for (int k = 0; k < 4; k++) chk("queue_drained", k, 32'(exp_q[k].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
